// File: rtl/siu_dmu_tx_sched_if.sv
// SIU-to-DMU outbound packet bus: two packet sources, DMU credit return and the DMU-facing strobes.
// master = scheduler side, slave = sources/DMU side.
interface siu_dmu_tx_sched_if #(
  parameter int unsigned CW = 3
);
  logic          req0_vld;
  logic [127:0]  req0_hdr;
  logic          req0_has_data;
  logic          req0_gnt;
  logic          req0_data_rd;
  logic [127:0]  req0_data;
  logic          req1_vld;
  logic [127:0]  req1_hdr;
  logic          req1_has_data;
  logic          req1_gnt;
  logic          req1_data_rd;
  logic [127:0]  req1_data;
  logic          dmu_sio_credit_ret;
  logic          sio_dmu_hdr_vld;
  logic          sio_dmu_datareq;
  logic [127:0]  sio_dmu_data;
  logic [7:0]    sio_dmu_parity;
  logic          sched_err;
  logic [CW-1:0] credit_cnt;

  modport master (
    input  req0_vld, req0_hdr, req0_has_data, req0_data,
    input  req1_vld, req1_hdr, req1_has_data, req1_data,
    input  dmu_sio_credit_ret,
    output req0_gnt, req0_data_rd, req1_gnt, req1_data_rd,
    output sio_dmu_hdr_vld, sio_dmu_datareq, sio_dmu_data, sio_dmu_parity,
    output sched_err, credit_cnt
  );

  modport slave (
    output req0_vld, req0_hdr, req0_has_data, req0_data,
    output req1_vld, req1_hdr, req1_has_data, req1_data,
    output dmu_sio_credit_ret,
    input  req0_gnt, req0_data_rd, req1_gnt, req1_data_rd,
    input  sio_dmu_hdr_vld, sio_dmu_datareq, sio_dmu_data, sio_dmu_parity,
    input  sched_err, credit_cnt
  );
endinterface

// File: rtl/siu_dmu_tx_sched.sv
// Credit-gated round-robin scheduler of SIU packets (header, optional gap + 4-beat payload) onto the DMU bus.
module siu_dmu_tx_sched #(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CW      = 3
) (
  input logic                 iol2clk,
  input logic                 rst,
  siu_dmu_tx_sched_if.master  bus
);

  typedef enum logic [1:0] {IDLE, HDR, GAP, DATA} state_t;

  state_t         state;
  logic [1:0]     beat_cnt;
  logic           cur_src;
  logic           cur_has_data;
  logic           rr_last;
  logic           hdr_vld_q;
  logic           datareq_q;
  logic [127:0]   data_q;
  logic           err_q;
  logic [CW-1:0]  cnt_q;

  logic           arb_slot;
  logic           credit_ok;
  logic           can_grant;
  logic           gnt0;
  logic           gnt1;
  logic           pop;
  logic [127:0]   pop_data;
  logic [7:0]     parity;

  // Grants and pops are combinational so a returned credit or a FWFT word is usable in the same cycle;
  // both are masked during reset so an abandoned packet never pops again.
  always_comb begin
    arb_slot  = (state == IDLE) || ((state == HDR) && !cur_has_data) ||
                ((state == DATA) && (beat_cnt == 2'd3));
    credit_ok = (cnt_q != '0) || bus.dmu_sio_credit_ret;
    can_grant = arb_slot && credit_ok && !rst;
    gnt0      = can_grant && bus.req0_vld && (!bus.req1_vld || rr_last);
    gnt1      = can_grant && bus.req1_vld && (!bus.req0_vld || !rr_last);
    pop       = !rst && ((state == GAP) || ((state == DATA) && (beat_cnt != 2'd3)));
    pop_data  = cur_src ? bus.req1_data : bus.req0_data;
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      cur_src      <= 1'b0;
      cur_has_data <= 1'b0;
      rr_last      <= 1'b1;
      hdr_vld_q    <= 1'b0;
      datareq_q    <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= CW'(CREDITS);
    end else begin
      hdr_vld_q <= 1'b0;
      datareq_q <= 1'b0;
      data_q    <= '0;
      case (state)
        IDLE: state <= IDLE;
        HDR:  state <= cur_has_data ? GAP : IDLE;
        GAP: begin
          state    <= DATA;
          beat_cnt <= '0;
          data_q   <= pop_data;
        end
        DATA: begin
          beat_cnt <= beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) state <= IDLE;
          else                  data_q <= pop_data;
        end
        default: state <= IDLE;
      endcase

      // A grant overrides the end-of-packet transition, giving back-to-back headers.
      if (gnt0 || gnt1) begin
        state        <= HDR;
        cur_src      <= gnt1;
        rr_last      <= gnt1;
        cur_has_data <= gnt1 ? bus.req1_has_data : bus.req0_has_data;
        hdr_vld_q    <= 1'b1;
        datareq_q    <= gnt1 ? bus.req1_has_data : bus.req0_has_data;
        data_q       <= gnt1 ? bus.req1_hdr : bus.req0_hdr;
      end

      if ((gnt0 || gnt1) && !bus.dmu_sio_credit_ret) begin
        cnt_q <= cnt_q - CW'(1);
      end else if (!(gnt0 || gnt1) && bus.dmu_sio_credit_ret) begin
        if (cnt_q == CW'(CREDITS)) err_q <= 1'b1;
        else                       cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    parity = '0;
    for (int unsigned i = 0; i < 8; i++) parity[i] = ^data_q[16*i +: 16];
  end

  assign bus.req0_gnt        = gnt0;
  assign bus.req1_gnt        = gnt1;
  assign bus.req0_data_rd    = pop && !cur_src;
  assign bus.req1_data_rd    = pop && cur_src;
  assign bus.sio_dmu_hdr_vld = hdr_vld_q;
  assign bus.sio_dmu_datareq = datareq_q;
  assign bus.sio_dmu_data    = data_q;
  assign bus.sio_dmu_parity  = parity;
  assign bus.sched_err       = err_q;
  assign bus.credit_cnt      = cnt_q;

endmodule

// File: tb/tb_siu_dmu_tx_sched.sv
// Directed bench for siu_dmu_tx_sched: scoreboard of expected packets checked by a bus monitor.
module tb_siu_dmu_tx_sched;

  logic iol2clk = 1'b0;
  logic rst;
  always #5 iol2clk = ~iol2clk;

  siu_dmu_tx_sched_if #(.CW(3)) bus ();

  siu_dmu_tx_sched #(.CREDITS(4), .CW(3)) dut (
    .iol2clk (iol2clk),
    .rst     (rst),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic             src;
    logic             has_data;
    logic [127:0]     hdr;
    logic [3:0][127:0] beats;
  } pkt_t;

  pkt_t expq[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  always @(posedge iol2clk) cyc <= cyc + 1;

  // FWFT payload sources: the word at the index is valid whenever data_rd is sampled.
  logic [127:0] pay0 [4];
  logic [127:0] pay1 [4];
  logic [1:0]   idx0, idx1;

  always @(posedge iol2clk) begin
    if (rst) begin
      idx0 <= '0;
      idx1 <= '0;
    end else begin
      if (bus.req0_data_rd) idx0 <= idx0 + 2'd1;
      if (bus.req1_data_rd) idx1 <= idx1 + 2'd1;
    end
  end

  assign bus.req0_data = pay0[idx0];
  assign bus.req1_data = pay1[idx1];

  function automatic logic [7:0] par16(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: pops one expected packet per header and follows it through gap and beats.
  int   mstate = 0;
  int   mbeat  = 0;
  pkt_t cur;

  always @(negedge iol2clk) begin
    if (rst) begin
      mstate = 0;
    end else begin
      case (mstate)
        0: begin
          if (bus.sio_dmu_hdr_vld) begin
            chk("hdr_expected", 128'(expq.size() != 0), 128'd1);
            if (expq.size() != 0) begin
              cur = expq.pop_front();
              chk("hdr_data", bus.sio_dmu_data, cur.hdr);
              chk("hdr_datareq", 128'(bus.sio_dmu_datareq), 128'(cur.has_data));
              chk("hdr_parity", 128'(bus.sio_dmu_parity), 128'(par16(cur.hdr)));
              if (cur.has_data) mstate = 1;
            end
          end else begin
            chk("idle_out", {bus.sio_dmu_datareq, bus.sio_dmu_parity, bus.sio_dmu_data[118:0]}, 128'd0);
            chk("idle_data_hi", 128'(bus.sio_dmu_data[127:119]), 128'd0);
          end
        end
        1: begin
          chk("gap_data", bus.sio_dmu_data, 128'd0);
          chk("gap_strobes", 128'({bus.sio_dmu_hdr_vld, bus.sio_dmu_datareq}), 128'd0);
          chk("gap_parity", 128'(bus.sio_dmu_parity), 128'd0);
          chk("gap_data_rd", 128'(cur.src ? bus.req1_data_rd : bus.req0_data_rd), 128'd1);
          mstate = 2;
          mbeat  = 0;
        end
        default: begin
          chk("beat_data", bus.sio_dmu_data, cur.beats[mbeat]);
          chk("beat_parity", 128'(bus.sio_dmu_parity), 128'(par16(cur.beats[mbeat])));
          chk("beat_strobes", 128'({bus.sio_dmu_hdr_vld, bus.sio_dmu_datareq}), 128'd0);
          chk("beat_data_rd", 128'(cur.src ? bus.req1_data_rd : bus.req0_data_rd), 128'(mbeat < 3));
          mbeat++;
          if (mbeat == 4) mstate = 0;
        end
      endcase
    end
  end

  task automatic push(input logic src, input logic has, input logic [127:0] hdr,
                      input logic [3:0][127:0] beats);
    pkt_t p;
    p.src = src; p.has_data = has; p.hdr = hdr; p.beats = beats;
    expq.push_back(p);
  endtask

  // Raise a request, wait (bounded) for its grant, then drop vld after the granting edge.
  task automatic send(input logic src, input logic [127:0] hdr, input logic has,
                      input logic [3:0][127:0] beats, output int unsigned gcyc);
    bit got = 0;
    if (src) begin
      for (int k = 0; k < 4; k++) pay1[k] = beats[k];
      bus.req1_hdr = hdr; bus.req1_has_data = has; bus.req1_vld = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) pay0[k] = beats[k];
      bus.req0_hdr = hdr; bus.req0_has_data = has; bus.req0_vld = 1'b1;
    end
    gcyc = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (src ? bus.req1_gnt : bus.req0_gnt) begin got = 1; gcyc = cyc; break; end
      @(negedge iol2clk);
    end
    chk("send_gnt", 128'(got), 128'd1);
    @(posedge iol2clk); #1;
    if (src) bus.req1_vld = 1'b0; else bus.req0_vld = 1'b0;
  endtask

  task automatic ret_credits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iol2clk); #1 bus.dmu_sio_credit_ret = 1'b1;
    end
    @(negedge iol2clk); #1 bus.dmu_sio_credit_ret = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge iol2clk);
      if (expq.size() == 0 && mstate == 0) break;
    end
    chk("drain", 128'(expq.size() == 0 && mstate == 0), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][127:0] zero_b, b2, b4, b6;
    int unsigned g, g2;
    int unsigned k;
    bit got;
    logic exp_order [5];

    zero_b = '0;
    b2 = {{8{16'hFFFF}}, 128'd0, {8{16'h5555}}, {8{16'hAAAA}}};
    b4 = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
    b6 = {{16{8'hC4}}, {16{8'hC3}}, {16{8'hC2}}, {16{8'hC1}}};
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1; exp_order[4] = 0;

    rst = 1'b1;
    bus.req0_vld = 0; bus.req0_hdr = '0; bus.req0_has_data = 0;
    bus.req1_vld = 0; bus.req1_hdr = '0; bus.req1_has_data = 0;
    bus.dmu_sio_credit_ret = 0;
    for (int i = 0; i < 4; i++) begin pay0[i] = '0; pay1[i] = '0; end

    repeat (3) @(posedge iol2clk);
    @(negedge iol2clk);
    chk("rst_credit", 128'(bus.credit_cnt), 128'd4);
    chk("rst_err", 128'(bus.sched_err), 128'd0);
    chk("rst_out", {bus.sio_dmu_hdr_vld, bus.sio_dmu_datareq, bus.sio_dmu_parity, bus.sio_dmu_data[117:0]}, 128'd0);
    chk("rst_rd", 128'({bus.req0_data_rd, bus.req1_data_rd}), 128'd0);
    #1 rst = 1'b0;

    // single no-data packet from source 0
    @(negedge iol2clk); #1;
    push(0, 0, 128'h1, zero_b);
    send(0, 128'h1, 0, zero_b, g);
    @(negedge iol2clk);
    chk("t1_hdr_cycle", 128'(cyc), 128'(g + 1));
    chk("t1_hdr_vld", 128'(bus.sio_dmu_hdr_vld), 128'd1);
    chk("t1_datareq", 128'(bus.sio_dmu_datareq), 128'd0);
    chk("t1_data", bus.sio_dmu_data, 128'h1);
    chk("t1_parity", 128'(bus.sio_dmu_parity), 128'h01);
    chk("t1_credit", 128'(bus.credit_cnt), 128'd3);
    drain();

    // source 1 payload packet; gap, beats and data_rd timing checked by the monitor
    #1 push(1, 1, 128'h77, b2);
    send(1, 128'h77, 1, b2, g);
    @(negedge iol2clk);
    chk("t2_datareq", 128'(bus.sio_dmu_datareq), 128'd1);
    @(negedge iol2clk);
    chk("t2_gap_rd1", 128'(bus.req1_data_rd), 128'd1);
    drain();
    ret_credits(2);
    @(negedge iol2clk);
    chk("t2_credit_back", 128'(bus.credit_cnt), 128'd4);

    // both sources valid: alternate grants until credits run out
    #1;
    for (int i = 0; i < 5; i++) push(exp_order[i], 0, exp_order[i] ? 128'hA1 : 128'hA0, zero_b);
    bus.req0_hdr = 128'hA0; bus.req0_has_data = 0;
    bus.req1_hdr = 128'hA1; bus.req1_has_data = 0;
    bus.req0_vld = 1; bus.req1_vld = 1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.req0_gnt || bus.req1_gnt) begin
        if (k < 4) chk("t3_order", 128'(bus.req1_gnt), 128'(exp_order[k]));
        k++;
      end
      @(negedge iol2clk);
    end
    chk("t3_grants_before_stall", 128'(k), 128'd4);
    chk("t3_credit_zero", 128'(bus.credit_cnt), 128'd0);
    #1 bus.dmu_sio_credit_ret = 1;
    #1 chk("t3_ret_gnt", 128'({bus.req1_gnt, bus.req0_gnt}), 128'b01);
    @(posedge iol2clk); #1 bus.dmu_sio_credit_ret = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iol2clk); #1;
      chk("t3_no_more_gnt", 128'({bus.req1_gnt, bus.req0_gnt}), 128'd0);
    end
    chk("t3_credit_still_zero", 128'(bus.credit_cnt), 128'd0);
    bus.req0_vld = 0; bus.req1_vld = 0;
    drain();
    ret_credits(4);
    @(negedge iol2clk);
    chk("t3_credit_back", 128'(bus.credit_cnt), 128'd4);

    // back-to-back: req1 header must follow req0's last beat directly
    #1;
    push(0, 1, 128'hB0, b4);
    push(1, 0, 128'hB1, zero_b);
    send(0, 128'hB0, 1, b4, g);
    bus.req1_hdr = 128'hB1; bus.req1_has_data = 0; bus.req1_vld = 1;
    got = 0; g2 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req1_gnt) begin got = 1; g2 = cyc; break; end
      @(negedge iol2clk);
    end
    chk("t4_gnt1_seen", 128'(got), 128'd1);
    chk("t4_gnt1_cycle", 128'(g2), 128'(g + 6));
    @(posedge iol2clk); #1 bus.req1_vld = 0;
    @(negedge iol2clk);
    chk("t4_hdr_vld", 128'(bus.sio_dmu_hdr_vld), 128'd1);
    chk("t4_hdr_data", bus.sio_dmu_data, 128'hB1);
    drain();
    ret_credits(2);

    // credit overflow
    @(negedge iol2clk);
    chk("t5_credit_full", 128'(bus.credit_cnt), 128'd4);
    chk("t5_err_before", 128'(bus.sched_err), 128'd0);
    ret_credits(1);
    chk("t5_err_set", 128'(bus.sched_err), 128'd1);
    chk("t5_credit_held", 128'(bus.credit_cnt), 128'd4);
    @(negedge iol2clk);
    chk("t5_err_sticky", 128'(bus.sched_err), 128'd1);

    // reset during beat 1 of a payload
    #1 push(1, 1, 128'hC0, b6);
    send(1, 128'hC0, 1, b6, g);
    for (int i = 0; i < 10; i++) begin
      @(negedge iol2clk);
      if (cyc == g + 4) break;
    end
    chk("t6_at_beat1", bus.sio_dmu_data, b6[1]);
    #1 rst = 1'b1;
    #1 chk("t6_rd_masked", 128'(bus.req1_data_rd), 128'd0);
    @(negedge iol2clk);
    chk("t6_out_zero", {bus.sio_dmu_hdr_vld, bus.sio_dmu_datareq, bus.sio_dmu_parity, bus.sio_dmu_data[117:0]}, 128'd0);
    chk("t6_rd_zero", 128'({bus.req0_data_rd, bus.req1_data_rd}), 128'd0);
    chk("t6_credit", 128'(bus.credit_cnt), 128'd4);
    chk("t6_err_cleared", 128'(bus.sched_err), 128'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iol2clk); #1;
      chk("t6_no_rd", 128'({bus.req0_data_rd, bus.req1_data_rd}), 128'd0);
    end
    push(0, 0, 128'hD0, zero_b);
    push(1, 0, 128'hD1, zero_b);
    bus.req0_hdr = 128'hD0; bus.req0_has_data = 0;
    bus.req1_hdr = 128'hD1; bus.req1_has_data = 0;
    bus.req0_vld = 1; bus.req1_vld = 1;
    #1 chk("t6_tie_req0", 128'({bus.req1_gnt, bus.req0_gnt}), 128'b01);
    @(posedge iol2clk); #1 bus.req0_vld = 0;
    #1 chk("t6_then_req1", 128'({bus.req1_gnt, bus.req0_gnt}), 128'b10);
    @(posedge iol2clk); #1 bus.req1_vld = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
